uart_rx_frame: RTL and testbench
================================

// Module: uart_rx_frame
// PURPOSE
//  UART receive stage that sits directly upstream of the system controller.
//  It oversamples the serial RX_IN line and deframes start / data / optional parity / stop bits.
//  It delivers each good byte as P_DATA with a one-cycle data_valid pulse; these feed RX_p_data / RX_d_valid.
//  Parity and framing faults are flagged, and the faulty byte is never forwarded.
// PARAMETERS
//  Data_width  8  payload bits per frame, sent LSB first
// PORTS
//  CLK           in   1           RX oversampling clock (single clock domain)
//  RST           in   1           synchronous reset, active-low
//  RX_IN         in   1           serial line (idle high), already synchronised to CLK
//  Prescale      in   6           oversampling ratio: 8, 16 or 32 only
//  PAR_EN        in   1           1 = frame carries a parity bit
//  PAR_TYP       in   1           0 = even, 1 = odd parity
//  P_DATA        out  Data_width  last good byte; held between frames
//  data_valid    out  1           1-cycle pulse, P_DATA new and valid
//  parity_error  out  1           1-cycle pulse, frame dropped on parity mismatch
//  stop_error    out  1           1-cycle pulse, frame dropped, stop bit sampled 0
// BEHAVIOUR
//  Reset: RST=0 at a CLK rising edge gives state IDLE, all counters 0, P_DATA=0 and all pulses 0.
//   Mid-frame reset aborts the frame silently, with no pulse.
//  Config: Prescale, PAR_EN and PAR_TYP are latched on start detect and held for the whole frame.
//   Mid-frame changes have no effect.
//  Counters:
//   - edge_cnt runs 0..P-1 once per bit period, where P is the latched Prescale.
//   - bit_cnt counts data bits 0..Data_width-1.
//  Sampling:
//   - RX_IN is sampled at edge_cnt = P/2-1, P/2 and P/2+1.
//   - The bit value is the 2-of-3 majority, registered at edge_cnt = P/2+1.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE
//   - IDLE: armed only after RX_IN=1 has been seen.
//     * Armed and RX_IN=0 -> START; this cycle is edge_cnt=0 of the start bit.
//   - START: at edge_cnt=P-1:
//     * sampled bit 1 -> glitch, back to IDLE, no pulse;
//     * else -> DATA.
//   - DATA: at each edge_cnt=P-1, the sampled bit is shifted into data[bit_cnt].
//     * After bit Data_width-1: PAR_EN ? PARITY : STOP.
//   - PARITY: expected bit = (^data) ^ PAR_TYP; a mismatch sets an internal par_bad flag.
//   - STOP: at edge_cnt=P-1, the frame completes:
//     * stop sample 0 -> stop_error=1 (takes priority over parity);
//     * else par_bad -> parity_error=1;
//     * else P_DATA<=data and data_valid=1.
//     * Exactly one of the three pulses fires per completed frame, in the next cycle, for 1 cycle.
//   - After STOP the FSM goes to IDLE.
//     * On a stop_error, IDLE stays disarmed until RX_IN=1, so a break does not retrigger.
//     * Otherwise IDLE is armed, so back-to-back frames are accepted with zero idle bits.
//  Latency: N = (2 + Data_width + PAR_EN) * P clocks per frame.
//   - The outcome pulse is high N clocks after the IDLE cycle that saw RX_IN=0.
//  Pulses never overlap. P_DATA changes only together with data_valid.
//  Illegal Prescale values are unsupported; the bench must not drive them.
// TESTING
//  1. P=8, no parity, RX_IN sends 0xA5 (LSB first) -> data_valid 1 cycle at start+80 clk, P_DATA=0xA5.
//  2. P=16, PAR_EN=1, PAR_TYP=0, byte 0x33 with parity bit 0 -> P_DATA=0x33 at start+176 clk;
//     same byte with parity bit 1 -> parity_error pulse, P_DATA stays 0x33.
//  3. P=32, odd parity, stop bit driven 0, line then held low 100 clk -> stop_error once, no new start;
//     RX_IN=1 then a 0x0F frame -> received correctly.
//  4. Start glitch: RX_IN low only 2 clk (P=8) -> FSM returns to IDLE, no pulse;
//     single-clock flip at sample P/2 inside a data bit -> majority vote recovers the bit.
//  5. Back-to-back 0x11 and 0x22 with no idle bits (P=8) -> two data_valid pulses 80 clk apart.
//  6. RST=0 during DATA of a 0xFF frame -> outputs cleared next edge;
//     no pulse until a fresh frame is received.

Source files
------------

// File: rtl/uart_rx_frame_if.sv
// Serial-line and result bundle between a UART receive deframer and its driver/consumer.
interface uart_rx_frame_if #(
    parameter int Data_width = 8
);
    logic                  RX_IN;
    logic [5:0]            Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [Data_width-1:0] P_DATA;
    logic                  data_valid;
    logic                  parity_error;
    logic                  stop_error;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, data_valid, parity_error, stop_error
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, data_valid, parity_error, stop_error
    );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receive deframer: oversampled start/data/parity/stop recovery with
// 2-of-3 majority bit sampling, forwarding only clean bytes.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a falling line; armed once the line was seen high
// START  | start bit; a high majority sample is treated as a glitch
// DATA   | Data_width payload bits, LSB first
// PARITY | optional parity bit, mismatch remembered in par_bad
// STOP   | stop bit; frame outcome pulse issued on its last oversample
module uart_rx_frame #(
    parameter int Data_width = 8
) (
    input  logic           CLK,
    input  logic           RST,
    uart_rx_frame_if.slave bus
);
    localparam int BW = (Data_width > 1) ? $clog2(Data_width) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(Data_width - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [5:0]            edge_cnt;
    logic [5:0]            p_lat;
    logic [5:0]            p_half;
    logic [5:0]            p_last;
    logic [BW-1:0]         bit_cnt;
    logic [Data_width-1:0] data;
    logic                  par_en_lat;
    logic                  par_typ_lat;
    logic                  par_bad;
    logic                  armed;
    logic                  samp_a;
    logic                  samp_b;
    logic                  bit_val;
    logic                  bit_done;

    assign p_half   = {1'b0, p_lat[5:1]};
    assign p_last   = p_lat - 6'd1;
    assign bit_done = (edge_cnt == p_last);

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; bit decisions are taken on the last oversample of each bit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (armed && !bus.RX_IN) begin
                    state_next = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next = bit_val ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_done && (bit_cnt == LAST_BIT)) begin
                    state_next = par_en_lat ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters, majority sampler, payload assembly and outcome pulses.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            edge_cnt         <= '0;
            bit_cnt          <= '0;
            p_lat            <= '0;
            par_en_lat       <= 1'b0;
            par_typ_lat      <= 1'b0;
            par_bad          <= 1'b0;
            armed            <= 1'b0;
            samp_a           <= 1'b0;
            samp_b           <= 1'b0;
            bit_val          <= 1'b0;
            data             <= '0;
            bus.P_DATA       <= '0;
            bus.data_valid   <= 1'b0;
            bus.parity_error <= 1'b0;
            bus.stop_error   <= 1'b0;
        end else begin
            bus.data_valid   <= 1'b0;
            bus.parity_error <= 1'b0;
            bus.stop_error   <= 1'b0;

            if (state == IDLE) begin
                // The detecting cycle is oversample 0 of the start bit.
                edge_cnt <= 6'd1;
                bit_cnt  <= '0;
                par_bad  <= 1'b0;
                if (bus.RX_IN) begin
                    armed <= 1'b1;
                end
                if (state_next == START) begin
                    p_lat       <= bus.Prescale;
                    par_en_lat  <= bus.PAR_EN;
                    par_typ_lat <= bus.PAR_TYP;
                end
            end else begin
                edge_cnt <= bit_done ? 6'd0 : edge_cnt + 6'd1;

                if (edge_cnt == p_half - 6'd1) begin
                    samp_a <= bus.RX_IN;
                end
                if (edge_cnt == p_half) begin
                    samp_b <= bus.RX_IN;
                end
                if (edge_cnt == p_half + 6'd1) begin
                    bit_val <= (samp_a & samp_b) | (samp_a & bus.RX_IN) | (samp_b & bus.RX_IN);
                end

                if (bit_done) begin
                    case (state)
                        DATA: begin
                            data[bit_cnt] <= bit_val;
                            bit_cnt       <= bit_cnt + 1'b1;
                        end
                        PARITY: begin
                            par_bad <= (bit_val != ((^data) ^ par_typ_lat));
                        end
                        STOP: begin
                            if (!bit_val) begin
                                // A break must go high before the next frame can start.
                                bus.stop_error <= 1'b1;
                                armed          <= 1'b0;
                            end else if (par_bad) begin
                                bus.parity_error <= 1'b1;
                            end else begin
                                bus.P_DATA     <= data;
                                bus.data_valid <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: frames are driven bit by bit, each
// frame's expected outcome and arrival cycle is queued, and every pulse
// seen on the DUT is matched against the head of that queue.
module tb_uart_rx_frame;
    localparam int K_VALID = 1;
    localparam int K_PAR   = 2;
    localparam int K_STOP  = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic CLK_tb = 1'b0;
    logic RST_tb = 1'b0;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    exp_t       sb[$];
    logic [7:0] prev_pdata = 8'h00;

    uart_rx_frame_if #(.Data_width(8)) bus ();

    uart_rx_frame #(.Data_width(8)) dut (
        .CLK (CLK_tb),
        .RST (RST_tb),
        .bus (bus)
    );

    // 10 ns oversampling clock.
    always #5 CLK_tb = ~CLK_tb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then compare any outcome pulse against the scoreboard.
    task automatic tick();
        logic rst_released;
        int   npulse;
        int   kind_obs;
        exp_t e;
        rst_released = RST_tb;
        @(posedge CLK_tb);
        #1;
        cyc++;
        npulse = int'(bus.data_valid) + int'(bus.parity_error) + int'(bus.stop_error);
        if (npulse != 0) begin
            chk("pulse_single", npulse, 1);
            chk("pulse_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                kind_obs = bus.data_valid ? K_VALID : (bus.parity_error ? K_PAR : K_STOP);
                chk("outcome_kind", kind_obs, e.kind);
                chk("outcome_cycle", cyc, e.cyc);
                if (e.kind == K_VALID) begin
                    chk("p_data", bus.P_DATA, e.data);
                end
            end
        end
        if (rst_released && (bus.P_DATA !== prev_pdata)) begin
            chk("p_data_change_with_valid", bus.data_valid, 1);
        end
        prev_pdata = bus.P_DATA;
    endtask

    task automatic idle(input int n);
        bus.RX_IN = 1'b1;
        repeat (n) tick();
    endtask

    // Drive one frame; config is scrambled right after start to prove it is latched.
    task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                              input bit bad_par, input bit stop_val, input int flip_bit);
        logic [10:0] bits;
        int          nbits;
        exp_t        e;
        logic        v;
        bits     = '1;
        bits[0]  = 1'b0;
        bits[8:1] = d;
        if (pen) begin
            bits[9]  = (^d) ^ ptyp ^ bad_par;
            bits[10] = stop_val;
        end else begin
            bits[9] = stop_val;
        end
        nbits = pen ? 11 : 10;
        if (!stop_val) e.kind = K_STOP;
        else if (pen && bad_par) e.kind = K_PAR;
        else e.kind = K_VALID;
        e.data = d;
        e.cyc  = cyc + nbits * p;
        sb.push_back(e);
        bus.Prescale = 6'(p);
        bus.PAR_EN   = pen;
        bus.PAR_TYP  = ptyp;
        for (int b = 0; b < nbits; b++) begin
            for (int k = 0; k < p; k++) begin
                v = bits[b];
                if ((b == flip_bit + 1) && (k == p / 2)) v = ~v;
                bus.RX_IN = v;
                if (b == 0 && k == 1) begin
                    bus.Prescale = (p == 8) ? 6'd32 : 6'd8;
                    bus.PAR_EN   = ~pen;
                    bus.PAR_TYP  = ~ptyp;
                end
                tick();
            end
        end
    endtask

    initial begin
        bus.RX_IN    = 1'b1;
        bus.Prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;

        // Reset state.
        RST_tb = 1'b0;
        repeat (4) tick();
        chk("rst_p_data", bus.P_DATA, 8'h00);
        chk("rst_data_valid", bus.data_valid, 0);
        chk("rst_parity_error", bus.parity_error, 0);
        chk("rst_stop_error", bus.stop_error, 0);
        RST_tb = 1'b1;
        idle(5);

        // 1: P=8, no parity, 0xA5.
        send_frame(8'hA5, 8, 0, 0, 0, 1, -1);
        idle(10);

        // 2: P=16, even parity, good then bad parity bit.
        send_frame(8'h33, 16, 1, 0, 0, 1, -1);
        idle(10);
        send_frame(8'h33, 16, 1, 0, 1, 1, -1);
        idle(10);
        chk("p_data_held_after_parity_error", bus.P_DATA, 8'h33);

        // 3: P=32, odd parity, stop bit 0, line held low, then a clean frame.
        send_frame(8'h5A, 32, 1, 1, 0, 0, -1);
        bus.RX_IN = 1'b0;
        repeat (100) tick();
        idle(64);
        send_frame(8'h0F, 32, 1, 1, 0, 1, -1);
        idle(10);

        // 4: short start glitch, then a one-clock flip inside data bit 2.
        bus.Prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.RX_IN    = 1'b0;
        repeat (2) tick();
        idle(30);
        chk("p_data_after_glitch", bus.P_DATA, 8'h0F);
        send_frame(8'h3C, 8, 0, 0, 0, 1, 2);
        idle(10);

        // 5: back-to-back frames with no idle bits.
        send_frame(8'h11, 8, 0, 0, 0, 1, -1);
        send_frame(8'h22, 8, 0, 0, 0, 1, -1);
        idle(10);

        // 6: reset in the middle of a 0xFF frame's data bits.
        bus.Prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.RX_IN    = 1'b0;
        repeat (8) tick();
        bus.RX_IN = 1'b1;
        repeat (27) tick();
        RST_tb = 1'b0;
        tick();
        chk("midrst_p_data", bus.P_DATA, 8'h00);
        chk("midrst_pulses", {bus.data_valid, bus.parity_error, bus.stop_error}, 3'b000);
        RST_tb = 1'b1;
        idle(100);
        chk("p_data_no_pulse_after_rst", bus.P_DATA, 8'h00);
        send_frame(8'h96, 8, 0, 0, 0, 1, -1);
        idle(20);

        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
